// File: rtl/imm_extender_pipe.sv
// rtl/imm_extender_pipe.sv - pipelined immediate extender (zero/sign/upper/branch), optional IMMEXT_COUNT_EN retire counter
module imm_extender_pipe #(
    parameter int IN_WIDTH  = 16,
    parameter int OUT_WIDTH = 32,
    parameter int DEPTH     = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en_n,
    input  logic                 flush,
    input  logic                 validIn,
    input  logic [IN_WIDTH-1:0]  dataIn,
    input  logic [1:0]           mode,
    output logic                 validOut,
    output logic [OUT_WIDTH-1:0] dataOut
`ifdef IMMEXT_COUNT_EN
    ,
    output logic [15:0]          extCount
`endif
);

    localparam int PAD = OUT_WIDTH - IN_WIDTH;

    if (OUT_WIDTH < IN_WIDTH + 2) begin : g_bad_width
        $error("imm_extender_pipe: OUT_WIDTH must be >= IN_WIDTH+2");
    end
    if (DEPTH < 1 || DEPTH > 8) begin : g_bad_depth
        $error("imm_extender_pipe: DEPTH must be in 1..8");
    end
    if (IN_WIDTH < 1) begin : g_bad_in
        $error("imm_extender_pipe: IN_WIDTH must be >= 1");
    end

    logic [OUT_WIDTH-1:0] sext;
    logic [OUT_WIDTH-1:0] ext;
    logic [OUT_WIDTH-1:0] s1_data_d;

    assign sext = {{PAD{dataIn[IN_WIDTH-1]}}, dataIn};

    always_comb begin
        ext = '0;
        case (mode)
            2'b00:   ext = {{PAD{1'b0}}, dataIn};
            2'b01:   ext = sext;
            2'b10:   ext = {dataIn, {PAD{1'b0}}};
            default: ext = {sext[OUT_WIDTH-3:0], 2'b00};
        endcase
    end

    // Bubbles always carry zero data so downstream never sees stale values.
    assign s1_data_d = validIn ? ext : '0;

    logic                 valid_q [DEPTH];
    logic [OUT_WIDTH-1:0] data_q  [DEPTH];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                valid_q[i] <= 1'b0;
                data_q[i]  <= '0;
            end
        end else if (!en_n) begin
            valid_q[0] <= validIn;
            data_q[0]  <= s1_data_d;
            for (int i = 1; i < DEPTH; i++) begin
                valid_q[i] <= valid_q[i-1];
                data_q[i]  <= data_q[i-1];
            end
        end
    end

    assign validOut = valid_q[DEPTH-1];
    assign dataOut  = data_q[DEPTH-1];

`ifdef IMMEXT_COUNT_EN
    logic [15:0] count_q;
    logic [15:0] count_d;

    // Flush does not clear the count; only a retiring result advances it.
    always_comb begin
        count_d = count_q;
        if (valid_q[DEPTH-1] && !en_n && !flush) begin
            count_d = count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign extCount = count_q;
`endif

endmodule

// File: tb/tb_imm_extender_pipe.sv
// tb/tb_imm_extender_pipe.sv - self-checking bench for imm_extender_pipe (vector table, corner sequences, random vs queue model)
module tb_imm_extender_pipe;

    localparam int IW = 16;
    localparam int OW = 32;
    localparam int DP = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en_n = 1'b0;
    logic          flush = 1'b0;
    logic          validIn = 1'b0;
    logic [IW-1:0] dataIn = '0;
    logic [1:0]    mode = 2'b00;
    logic          validOut;
    logic [OW-1:0] dataOut;
`ifdef IMMEXT_COUNT_EN
    logic [15:0]   extCount;
`endif

    int checks = 0;
    int errors = 0;

    imm_extender_pipe #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .DEPTH(DP)) dut (
        .clk(clk),
        .rst(rst),
        .en_n(en_n),
        .flush(flush),
        .validIn(validIn),
        .dataIn(dataIn),
        .mode(mode),
        .validOut(validOut),
        .dataOut(dataOut)
`ifdef IMMEXT_COUNT_EN
        ,
        .extCount(extCount)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] d;
        logic [1:0]  m;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        logic        v;
        logic [31:0] d;
    } ent_t;

    function automatic logic [31:0] ref_ext(logic [15:0] d, logic [1:0] m);
        longint u;
        longint s;
        u = longint'(d);
        s = (u >= 32768) ? u - 65536 : u;
        case (m)
            2'd0:    return 32'(u);
            2'd1:    return 32'(s);
            2'd2:    return 32'(u * 65536);
            default: return 32'(s * 4);
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic v, input logic [15:0] d, input logic [1:0] m);
        validIn = v;
        dataIn  = d;
        mode    = m;
    endtask

    vec_t vecs[10];
    ent_t mq[$];
    int   exp_cnt;

    initial begin
        vecs[0] = '{16'h8001, 2'b00, 32'h0000_8001};
        vecs[1] = '{16'h8001, 2'b01, 32'hFFFF_8001};
        vecs[2] = '{16'h0001, 2'b01, 32'h0000_0001};
        vecs[3] = '{16'h1234, 2'b10, 32'h1234_0000};
        vecs[4] = '{16'hFFFF, 2'b11, 32'hFFFF_FFFC};
        vecs[5] = '{16'h0004, 2'b11, 32'h0000_0010};
        vecs[6] = '{16'h8000, 2'b11, 32'hFFFE_0000};
        vecs[7] = '{16'h7FFF, 2'b01, 32'h0000_7FFF};
        vecs[8] = '{16'hFFFF, 2'b00, 32'h0000_FFFF};
        vecs[9] = '{16'h0001, 2'b10, 32'h0001_0000};

        // Reset with random inputs
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            en_n  = 1'($urandom);
            flush = 1'($urandom);
            put(1'($urandom), 16'($urandom), 2'($urandom));
            step();
            check("reset_valid", 32'(validOut), 32'd0);
            check("reset_data", dataOut, 32'd0);
        end
        rst = 1'b0;
        en_n = 1'b0;
        flush = 1'b0;
        put(1'b0, 16'h0, 2'b00);
        step();

        // Mode table: one transaction, then a bubble
        for (int i = 0; i < 10; i++) begin
            put(1'b1, vecs[i].d, vecs[i].m);
            step();
            check("vec_latency_valid", 32'(validOut), 32'd0);
            put(1'b0, 16'hDEAD, 2'b11);
            step();
            check("vec_valid", 32'(validOut), 32'd1);
            check("vec_data", dataOut, vecs[i].exp);
        end
        step();
        check("idle_valid", 32'(validOut), 32'd0);
        check("idle_data", dataOut, 32'd0);

        // Stall with A at the output and B behind it
        put(1'b1, 16'h0001, 2'b01);
        step();
        put(1'b1, 16'h0002, 2'b01);
        step();
        check("stall_a_data", dataOut, 32'h1);
        en_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            put(1'b1, 16'h7777, 2'b00);
            step();
            check("stall_hold_valid", 32'(validOut), 32'd1);
            check("stall_hold_data", dataOut, 32'h1);
        end
        en_n = 1'b0;
        put(1'b0, 16'h0, 2'b00);
        step();
        check("release_b_valid", 32'(validOut), 32'd1);
        check("release_b_data", dataOut, 32'h2);
        step();
        check("stall_no_capture_valid", 32'(validOut), 32'd0);
        check("stall_no_capture_data", dataOut, 32'd0);

        // Flush while stalled with two in flight
        put(1'b1, 16'h0011, 2'b00);
        step();
        put(1'b1, 16'h0022, 2'b00);
        step();
        check("preflush_data", dataOut, 32'h11);
        flush = 1'b1;
        en_n  = 1'b1;
        put(1'b1, 16'h5555, 2'b00);
        step();
        check("flush_valid", 32'(validOut), 32'd0);
        check("flush_data", dataOut, 32'd0);
        flush = 1'b0;
        en_n  = 1'b0;
        put(1'b1, 16'h0003, 2'b00);
        step();
        check("postflush_lat_valid", 32'(validOut), 32'd0);
        put(1'b0, 16'h0, 2'b00);
        step();
        check("postflush_valid", 32'(validOut), 32'd1);
        check("postflush_data", dataOut, 32'h3);

`ifdef IMMEXT_COUNT_EN
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("cnt_reset", 32'(extCount), 32'd0);
        for (int i = 0; i < 5; i++) begin
            put(1'b1, 16'(i), 2'b00);
            step();
        end
        put(1'b0, 16'h0, 2'b00);
        for (int i = 0; i < DP + 1; i++) step();
        check("cnt_five", 32'(extCount), 32'd5);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("cnt_after_flush", 32'(extCount), 32'd5);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("cnt_after_rst", 32'(extCount), 32'd0);
`endif

        // Random traffic against a queue model (index 0 = transaction on the output)
        rst = 1'b1;
        step();
        rst = 1'b0;
        mq.delete();
        for (int i = 0; i < DP; i++) mq.push_back('{1'b0, 32'd0});
        exp_cnt = 0;
        for (int n = 0; n < 400; n++) begin
            ent_t e;
            rst   = ($urandom_range(0, 59) == 0);
            flush = ($urandom_range(0, 19) == 0);
            en_n  = ($urandom_range(0, 3) == 0);
            put(1'($urandom), 16'($urandom), 2'($urandom));
            if (rst || flush) begin
                if (rst) exp_cnt = 0;
                mq.delete();
                for (int i = 0; i < DP; i++) mq.push_back('{1'b0, 32'd0});
            end else if (!en_n) begin
                if (mq[0].v) exp_cnt = (exp_cnt + 1) % 65536;
                e.v = validIn;
                e.d = validIn ? ref_ext(dataIn, mode) : 32'd0;
                void'(mq.pop_front());
                mq.push_back(e);
            end
            step();
            check("rand_valid", 32'(validOut), 32'(mq[0].v));
            check("rand_data", dataOut, mq[0].d);
`ifdef IMMEXT_COUNT_EN
            check("rand_count", 32'(extCount), 32'(exp_cnt));
`endif
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/imm_extender_pipe.md
Name: imm_extender_pipe

Overview:
Parametrised, pipelined immediate extender for the decode/execute path. Widens an IN_WIDTH immediate to OUT_WIDTH using one of four per-transaction modes: zero, sign, upper-load, or branch-offset. The result passes through a DEPTH-stage valid-tagged pipeline with stall (en_n) and flush control. It feeds the ALU operand mux and the branch-target adder.

Parameters:
IN_WIDTH, 16, immediate width in bits (>= 1)
OUT_WIDTH, 32, result width; must satisfy OUT_WIDTH >= IN_WIDTH+2, otherwise elaboration fails via generate-time $error
DEPTH, 2, number of pipeline register stages (1..8; outside this range, elaboration fails)

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  synchronous reset, active-high
en_n  input  1  active-low advance enable; 1 stalls every stage
flush  input  1  clears all in-flight transactions
validIn  input  1  dataIn/mode carry a transaction this cycle
dataIn  input  IN_WIDTH  raw immediate
mode  input  2  extension mode (see Behaviour)
validOut  output  1  dataOut holds a valid result
dataOut  output  OUT_WIDTH  extended result from the last stage

Behaviour:
- Mode encoding (combinational, computed before stage 1):
  - 00: zero-extend.
  - 01: sign-extend from bit IN_WIDTH-1.
  - 10: upper, {dataIn, (OUT_WIDTH-IN_WIDTH) zeros}, truncated to OUT_WIDTH.
  - 11: branch, sign-extend then shift left 2; low 2 bits are 0 and the top 2 extended bits are discarded.
- Pipeline: stages s[1..DEPTH], each holding {valid, data}. dataOut/validOut come directly from s[DEPTH]; there is no combinational path from inputs to outputs.
- Latency: exactly DEPTH rising edges with en_n=0 from sampling validIn=1 to validOut=1 with that result.
- Advance (en_n=0, flush=0):
  - s[1] <= {validIn, validIn ? ext(dataIn,mode) : 0}.
  - s[k] <= s[k-1] for k = 2..DEPTH.
  - A bubble (validIn=0) always carries data 0.
- Stall (en_n=1, flush=0): all stages hold; inputs are ignored (not captured). The upstream stage is responsible for holding its transaction.
- Flush (flush=1, rst=0): all stages load {0, 0} on the next edge, regardless of en_n. The input presented in that same cycle is discarded.
- Priority: rst > flush > en_n.
- Reset: on an edge with rst=1, all stages become {0, 0}, so validOut=0 and dataOut=0 from the next cycle. Reset mid-stream discards all in-flight data.
- Back-to-back: one transaction accepted per advancing cycle. Full throughput is one result per cycle; ordering is strictly preserved.
- Stall release: the transaction held in s[DEPTH] remains visible on the outputs for every stalled cycle and advances on the first en_n=0 edge.
- mode is ignored when validIn=0.

Optional Feature:
IMMEXT_COUNT_EN
- Defined:
  - Adds output extCount [15:0].
  - Increments by 1 on each edge where s[DEPTH].valid=1, en_n=0, flush=0 and rst=0, i.e. a result retires.
  - Wraps from 0xFFFF to 0x0000.
  - Cleared by rst; not cleared by flush.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
(All with IN_WIDTH=16, OUT_WIDTH=32, DEPTH=2.)
1. Reset: hold rst=1 for 5 cycles with random inputs -> validOut=0 and dataOut=0x00000000 every cycle after the first edge.
2. Modes 00/01 (en_n=0):
   - dataIn=0x8001, mode=00 -> 0x00008001 two edges later.
   - mode=01 -> 0xFFFF8001.
   - 0x0001, mode=01 -> 0x00000001.
   - validOut=1 only in those result cycles.
3. Modes 10/11:
   - 0x1234, mode=10 -> 0x12340000.
   - 0xFFFF, mode=11 -> 0xFFFFFFFC.
   - 0x0004, mode=11 -> 0x00000010.
   - 0x8000, mode=11 -> 0xFFFE0000.
4. Stall: stream A=0x0001, B=0x0002 (mode 01), then en_n=1 for 3 cycles once A reaches the output:
   - Outputs hold 0x00000001 with validOut=1 for all 3 cycles.
   - After release, B appears one edge later.
   - No inputs presented during the stall are captured.
5. Flush: with 2 valid transactions in flight, assert flush=1 for one cycle while en_n=1 -> next cycle validOut=0 and dataOut=0. A new input after flush emerges with latency 2.
6. IMMEXT_COUNT_EN defined:
   - 5 back-to-back valid inputs -> extCount=5 after the last retires.
   - flush then leaves extCount=5.
   - rst -> extCount=0.
